// File: rtl/clock_pkg.sv
// Shared definitions for the digital clock / LCD project.
//   - bcd_t        : one BCD digit
//   - LCD_*        : HD44780 command bytes used by the sequencer
//   - ASCII_*      : characters placed on the display
//   - seq_state_t  : LCD sequencer phases
//   - bcd_ascii()  : BCD digit to printable ASCII
package clock_pkg;

  typedef logic [3:0] bcd_t;

  localparam logic [7:0] LCD_FUNC_SET = 8'h38;  // 8-bit bus, 2 lines, 5x8 font
  localparam logic [7:0] LCD_DISP_ON  = 8'h0C;  // display on, cursor off
  localparam logic [7:0] LCD_ENTRY    = 8'h06;  // increment, no shift
  localparam logic [7:0] LCD_CLEAR    = 8'h01;
  localparam logic [7:0] LCD_LINE1    = 8'h80;
  localparam logic [7:0] LCD_LINE2    = 8'hC0;

  localparam logic [7:0] ASCII_0     = 8'h30;
  localparam logic [7:0] ASCII_SPACE = 8'h20;
  localparam logic [7:0] ASCII_COLON = 8'h3A;
  localparam logic [7:0] ASCII_A     = 8'h41;
  localparam logic [7:0] ASCII_E     = 8'h45;
  localparam logic [7:0] ASCII_I     = 8'h49;
  localparam logic [7:0] ASCII_M     = 8'h4D;
  localparam logic [7:0] ASCII_N     = 8'h4E;
  localparam logic [7:0] ASCII_P     = 8'h50;
  localparam logic [7:0] ASCII_R     = 8'h52;
  localparam logic [7:0] ASCII_S     = 8'h53;
  localparam logic [7:0] ASCII_T     = 8'h54;
  localparam logic [7:0] ASCII_U     = 8'h55;

  typedef enum logic [1:0] {
    SEQ_POWER,    // idle steps after reset
    SEQ_INIT,     // four init commands
    SEQ_CLRWAIT,  // idle steps while the clear command completes
    SEQ_FRAME     // 21-step refresh frame, repeats forever
  } seq_state_t;

  function automatic logic [7:0] bcd_ascii(input bcd_t d);
    return ASCII_0 + {4'h0, d};
  endfunction

endpackage

// File: rtl/lcd_byte_writer.sv
// One LCD bus transfer per step of STEP_CYCLES cycles.
//   clk, rst_n : clock, asynchronous active-low reset
//   start      : accepted while done=1; latches byte_in/rs_in/strobe
//   strobe     : 1 = pulse E during the step, 0 = idle (timing-only) step
//   done       : high while idle and in the last cycle of a step, so
//                back-to-back starts give gapless steps
//   e, rs, data: registered LCD pins; rs/data hold for the whole step
module lcd_byte_writer
  import clock_pkg::*;
#(
  parameter int STEP_CYCLES = 5000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       strobe,
  input  logic       rs_in,
  input  logic [7:0] byte_in,
  output logic       done,
  output logic       e,
  output logic       rs,
  output logic [7:0] data
);

  localparam int CW = $clog2(STEP_CYCLES + 1);
  localparam logic [CW-1:0] LAST  = CW'(STEP_CYCLES - 1);
  localparam logic [CW-1:0] E_ON  = CW'(STEP_CYCLES / 4);
  localparam logic [CW-1:0] E_OFF = CW'(3 * STEP_CYCLES / 4);

  logic          busy;
  logic          strobe_q;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_nxt;
  logic          last;

  assign last    = busy && (cnt == LAST);
  assign done    = !busy || last;
  assign cnt_nxt = cnt + 1'b1;

  // e is registered from the next count so it is high exactly while
  // cnt lies in [E_ON, E_OFF).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy     <= 1'b0;
      strobe_q <= 1'b0;
      cnt      <= '0;
      e        <= 1'b0;
      rs       <= 1'b0;
      data     <= '0;
    end else if (start && done) begin
      busy     <= 1'b1;
      strobe_q <= strobe;
      cnt      <= '0;
      e        <= 1'b0;
      rs       <= rs_in;
      data     <= byte_in;
    end else if (busy && !last) begin
      cnt <= cnt_nxt;
      e   <= strobe_q && (cnt_nxt >= E_ON) && (cnt_nxt < E_OFF);
    end else begin
      busy <= 1'b0;
      e    <= 1'b0;
    end
  end

endmodule

// File: rtl/digital_clock_lcd.sv
// 24-hour BCD real-time clock with keypad time-set, driving an HD44780 LCD.
//   clock  : system clock
//   reset  : asynchronous active-low reset
//   mode   : [0] time-set, [1] 12-hour display, [6:2] unused
//   button : [9:0] digits, [10] cursor back, [11] cursor forward
//   E/RS/RW/DATA : write-only 8-bit LCD bus (RW tied low)
module digital_clock_lcd
  import clock_pkg::*;
#(
  parameter int SEC_CYCLES      = 100_000_000,
  parameter int LCD_STEP_CYCLES = 5000,
  parameter int POWERUP_STEPS   = 400,
  parameter int CLEAR_STEPS     = 40
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [6:0]  mode,
  input  logic [11:0] button,
  output logic        E,
  output logic        RS,
  output logic        RW,
  output logic [7:0]  DATA
);

  localparam int PW   = $clog2(SEC_CYCLES);
  localparam int IW_P = $clog2(POWERUP_STEPS + 1);
  localparam int IW_C = $clog2(CLEAR_STEPS + 1);
  localparam int IW_M = (IW_P > IW_C) ? IW_P : IW_C;
  localparam int IW   = (IW_M > 5) ? IW_M : 5;

  logic          unused_mode;
  logic [PW-1:0] presc;
  logic          tick;
  bcd_t          ht, hu, mt, mu, st, su;
  logic [2:0]    cursor;
  logic          mode0_q;
  logic [11:0]   btn_p0, btn_p1, btn_p2;
  logic [11:0]   edges;
  logic          key_vld;
  logic [3:0]    key;
  logic          legal;

  assign unused_mode = ^mode[6:2];
  assign RW          = 1'b0;
  assign tick        = !mode[0] && (presc == PW'(SEC_CYCLES - 1));
  assign edges       = btn_p1 & ~btn_p2;

  // Only the lowest-numbered rising edge acts.
  always_comb begin
    key_vld = 1'b0;
    key     = '0;
    for (int i = 11; i >= 0; i--) begin
      if (edges[i]) begin
        key_vld = 1'b1;
        key     = 4'(i);
      end
    end
  end

  always_comb begin
    legal = 1'b1;
    case (cursor)
      3'd0:       legal = (key <= 4'd2);
      3'd1:       legal = (ht == 4'd2) ? (key <= 4'd3) : 1'b1;
      3'd2, 3'd4: legal = (key <= 4'd5);
      default:    legal = 1'b1;
    endcase
  end

  // Stage p0/p1: synchronizer; p2: previous value for edge detect.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      btn_p0 <= '0;
      btn_p1 <= '0;
      btn_p2 <= '0;
    end else begin
      btn_p0 <= button;
      btn_p1 <= btn_p0;
      btn_p2 <= btn_p1;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      presc   <= '0;
      mode0_q <= 1'b0;
      cursor  <= '0;
      {ht, hu, mt, mu, st, su} <= '0;
    end else begin
      mode0_q <= mode[0];
      if (mode[0] || tick) presc <= '0;
      else                 presc <= presc + 1'b1;

      if (tick) begin
        if (su != 4'd9) su <= su + 1'b1;
        else begin
          su <= '0;
          if (st != 4'd5) st <= st + 1'b1;
          else begin
            st <= '0;
            if (mu != 4'd9) mu <= mu + 1'b1;
            else begin
              mu <= '0;
              if (mt != 4'd5) mt <= mt + 1'b1;
              else begin
                mt <= '0;
                if (ht == 4'd2 && hu == 4'd3) begin
                  ht <= '0;
                  hu <= '0;
                end else if (hu == 4'd9) begin
                  hu <= '0;
                  ht <= ht + 1'b1;
                end else hu <= hu + 1'b1;
              end
            end
          end
        end
      end else if (mode[0] && !mode0_q) begin
        cursor <= '0;
      end else if (mode[0] && key_vld) begin
        if (key <= 4'd9) begin
          if (legal) begin
            case (cursor)
              3'd0: begin
                ht <= key;
                if (key == 4'd2 && hu > 4'd3) hu <= 4'd3;
              end
              3'd1:    hu <= key;
              3'd2:    mt <= key;
              3'd3:    mu <= key;
              3'd4:    st <= key;
              default: su <= key;
            endcase
            cursor <= (cursor == 3'd5) ? 3'd0 : cursor + 1'b1;
          end
        end else if (key == 4'd10) begin
          cursor <= (cursor == 3'd0) ? 3'd5 : cursor - 1'b1;
        end else begin
          cursor <= (cursor == 3'd5) ? 3'd0 : cursor + 1'b1;
        end
      end
    end
  end

  // Displayed hour: 24-hour value or its 12-hour form.
  logic [4:0] h24, hshow;
  bcd_t       dht, dhu;
  logic       pm;

  always_comb begin
    h24   = 5'({1'b0, ht}) * 5'd10 + 5'({1'b0, hu});
    pm    = (h24 >= 5'd12);
    hshow = h24;
    if (mode[1]) begin
      if (h24 == 5'd0)       hshow = 5'd12;
      else if (h24 > 5'd12)  hshow = h24 - 5'd12;
    end
    if (hshow >= 5'd20) begin
      dht = 4'd2;
      dhu = 4'(hshow - 5'd20);
    end else if (hshow >= 5'd10) begin
      dht = 4'd1;
      dhu = 4'(hshow - 5'd10);
    end else begin
      dht = 4'd0;
      dhu = 4'(hshow);
    end
  end

  // Sequence ROM: what the next step sends, sampled as the step starts.
  seq_state_t    seq_st;
  logic [IW-1:0] idx;
  logic [4:0]    fidx;
  logic          wr_done, w_strobe, w_rs;
  logic [7:0]    w_byte;

  assign fidx = idx[4:0];

  always_comb begin
    w_strobe = 1'b0;
    w_rs     = 1'b0;
    w_byte   = '0;
    case (seq_st)
      SEQ_INIT: begin
        w_strobe = 1'b1;
        case (fidx[1:0])
          2'd0:    w_byte = LCD_FUNC_SET;
          2'd1:    w_byte = LCD_DISP_ON;
          2'd2:    w_byte = LCD_ENTRY;
          default: w_byte = LCD_CLEAR;
        endcase
      end
      SEQ_FRAME: begin
        w_strobe = 1'b1;
        w_rs     = 1'b1;
        w_byte   = ASCII_SPACE;
        case (fidx)
          5'd0:  begin w_rs = 1'b0; w_byte = LCD_LINE1; end
          5'd1:  w_byte = ASCII_T;
          5'd2:  w_byte = ASCII_I;
          5'd3:  w_byte = ASCII_M;
          5'd4:  w_byte = ASCII_E;
          5'd6:  w_byte = bcd_ascii(dht);
          5'd7:  w_byte = bcd_ascii(dhu);
          5'd8:  w_byte = ASCII_COLON;
          5'd9:  w_byte = bcd_ascii(mt);
          5'd10: w_byte = bcd_ascii(mu);
          5'd11: w_byte = ASCII_COLON;
          5'd12: w_byte = bcd_ascii(st);
          5'd13: w_byte = bcd_ascii(su);
          5'd14: begin w_rs = 1'b0; w_byte = LCD_LINE2; end
          5'd15: w_byte = mode[0] ? ASCII_S : ASCII_R;
          5'd16: w_byte = mode[0] ? ASCII_E : ASCII_U;
          5'd17: w_byte = mode[0] ? ASCII_T : ASCII_N;
          5'd19: w_byte = mode[1] ? (pm ? ASCII_P : ASCII_A) : ASCII_SPACE;
          5'd20: w_byte = mode[1] ? ASCII_M : ASCII_SPACE;
          default: w_byte = ASCII_SPACE;
        endcase
      end
      default: ;
    endcase
  end

  // A new step is issued every time the writer is ready.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      seq_st <= SEQ_POWER;
      idx    <= '0;
    end else if (wr_done) begin
      case (seq_st)
        SEQ_POWER:
          if (idx == IW'(POWERUP_STEPS - 1)) begin
            seq_st <= SEQ_INIT;
            idx    <= '0;
          end else idx <= idx + 1'b1;
        SEQ_INIT:
          if (idx == IW'(3)) begin
            seq_st <= (CLEAR_STEPS > 1) ? SEQ_CLRWAIT : SEQ_FRAME;
            idx    <= '0;
          end else idx <= idx + 1'b1;
        SEQ_CLRWAIT:
          if (idx == IW'(CLEAR_STEPS - 2)) begin
            seq_st <= SEQ_FRAME;
            idx    <= '0;
          end else idx <= idx + 1'b1;
        default:
          idx <= (idx == IW'(20)) ? '0 : idx + 1'b1;
      endcase
    end
  end

  lcd_byte_writer #(
    .STEP_CYCLES(LCD_STEP_CYCLES)
  ) u_writer (
    .clk     (clock),
    .rst_n   (reset),
    .start   (wr_done),
    .strobe  (w_strobe),
    .rs_in   (w_rs),
    .byte_in (w_byte),
    .done    (wr_done),
    .e       (E),
    .rs      (RS),
    .data    (DATA)
  );

endmodule

// File: tb/tb_digital_clock_lcd.sv
module tb_digital_clock_lcd;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [6:0]  mode = '0;
  logic [11:0] button = '0;
  logic        E, RS, RW;
  logic [7:0]  DATA;

  always #5 clock = ~clock;

  digital_clock_lcd #(
    .SEC_CYCLES(100), .LCD_STEP_CYCLES(20), .POWERUP_STEPS(2), .CLEAR_STEPS(4)
  ) dut (
    .clock(clock), .reset(reset), .mode(mode), .button(button),
    .E(E), .RS(RS), .RW(RW), .DATA(DATA)
  );

  typedef struct packed {
    logic       rs;
    logic [7:0] data;
    logic [7:0] len;
  } xfer_t;

  xfer_t      xq[$];
  int         checks = 0;
  int         errors = 0;
  int         cyc = 0;
  bit         timed_out = 0;
  bit         rw_bad = 0;
  bit         e_prev = 0;
  logic       cur_rs;
  logic [7:0] cur_data;
  logic [7:0] e_len;

  always @(posedge clock) if (reset) cyc++;

  // Bus monitor: one record per E pulse, with its width in cycles.
  always @(negedge clock) begin
    if (RW !== 1'b0) rw_bad = 1;
    if (!reset) begin
      e_prev = 0;
    end else begin
      if (E === 1'b1) begin
        if (!e_prev) begin
          cur_rs   = RS;
          cur_data = DATA;
          e_len    = 0;
        end
        e_len = e_len + 1;
      end else if (e_prev) begin
        xq.push_back('{rs: cur_rs, data: cur_data, len: e_len});
      end
      e_prev = (E === 1'b1);
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_s(input string tag, input string obs, input string exp);
    checks++;
    assert (obs == exp) else begin
      errors++;
      $error("FAIL %s: observed \"%s\" expected \"%s\"", tag, obs, exp);
    end
  endtask

  task automatic get_xfer(output xfer_t x);
    int waited = 0;
    while (xq.size() == 0 && waited < 2000 && !timed_out) begin
      @(negedge clock);
      waited++;
    end
    if (xq.size() == 0) begin
      if (!timed_out) begin
        checks++;
        errors++;
        $error("FAIL xfer_timeout: observed no E pulse, expected one within 2000 cycles");
      end
      timed_out = 1;
      x = '0;
    end else begin
      x = xq.pop_front();
    end
  endtask

  function automatic string app(string s, xfer_t x);
    return x.rs ? $sformatf("%s%c", s, x.data) : {s, "?"};
  endfunction

  // Drops anything already captured, syncs on the next line-1 command and
  // returns both lines; a character sent as a command shows as '?'.
  task automatic read_frame(output string l1, output string l2);
    xfer_t x;
    int    n = 0;
    l1 = "";
    l2 = "";
    xq.delete();
    get_xfer(x);
    while (!(x.rs == 1'b0 && x.data == 8'h80) && n < 40 && !timed_out) begin
      get_xfer(x);
      n++;
    end
    for (int i = 0; i < 13; i++) begin
      get_xfer(x);
      l1 = app(l1, x);
    end
    get_xfer(x);
    if (!(x.rs == 1'b0 && x.data == 8'hC0)) l2 = "!";
    for (int i = 0; i < 6; i++) begin
      get_xfer(x);
      l2 = app(l2, x);
    end
  endtask

  task automatic press(input logic [11:0] b);
    button = b;
    repeat (6) @(negedge clock);
    button = '0;
    repeat (6) @(negedge clock);
  endtask

  task automatic key(input int d);
    press(12'(1) << d);
  endtask

  initial begin
    xfer_t x;
    string l1, l2;
    logic [7:0] init_cmd [4];
    string s;

    init_cmd[0] = 8'h38; init_cmd[1] = 8'h0C;
    init_cmd[2] = 8'h06; init_cmd[3] = 8'h01;

    // Reset state
    #2 reset = 1'b0;
    repeat (3) @(negedge clock);
    chk("rst_E", E, 1'b0);
    chk("rst_RS", RS, 1'b0);
    chk("rst_DATA", DATA, 8'h00);
    reset = 1'b1;

    // Init commands, each with a 10-cycle E pulse
    for (int i = 0; i < 4; i++) begin
      get_xfer(x);
      chk($sformatf("init%0d_cmd", i), {x.rs, x.data}, {1'b0, init_cmd[i]});
      chk($sformatf("init%0d_len", i), x.len, 8'd10);
    end
    get_xfer(x);
    chk("first_line1_cmd", {x.rs, x.data}, {1'b0, 8'h80});
    // Seconds run from release: the S-units step starts at edge 441 -> 4 ticks.
    s = "";
    for (int i = 0; i < 13; i++) begin
      get_xfer(x);
      s = app(s, x);
    end
    chk_s("first_line1", s, "TIME 00:00:04");

    // 60 ticks by edge 6000; freeze half a second later
    while (cyc < 6050) @(negedge clock);
    mode = 7'b0000001;
    read_frame(l1, l2);
    chk_s("run_6000_l1", l1, "TIME 00:01:00");
    chk_s("set_l2", l2, "SET   ");

    // Preset 23:59:59, one tick rolls to midnight
    key(2); key(3); key(5); key(9); key(5); key(9);
    read_frame(l1, l2);
    chk_s("preset_l1", l1, "TIME 23:59:59");
    mode = 7'b0000000;
    repeat (150) @(negedge clock);
    mode = 7'b0000001;
    read_frame(l1, l2);
    chk_s("rollover_l1", l1, "TIME 00:00:00");

    // Full keypad entry, then confirm time is frozen
    key(2); key(3); key(5); key(9); key(5); key(8);
    read_frame(l1, l2);
    chk_s("entry_l1", l1, "TIME 23:59:58");
    chk_s("entry_l2", l2, "SET   ");
    repeat (1000) @(negedge clock);
    read_frame(l1, l2);
    chk_s("frozen_l1", l1, "TIME 23:59:58");

    // Illegal Hu ignored, back-wrap 0->5
    key(2); key(9); key(1);
    key(10); key(10); key(10);
    key(7);
    read_frame(l1, l2);
    chk_s("illegal_wrap_l1", l1, "TIME 21:59:57");

    // Ht=2 clamps Hu from 8 to 3
    key(1); key(8); key(10); key(10); key(2);
    read_frame(l1, l2);
    chk_s("clamp_l1", l1, "TIME 23:59:57");

    // Cursor forward to Mu, then 3 and 7 together: only 3 lands
    key(11); key(11);
    press(12'b0000_1000_1000);
    read_frame(l1, l2);
    chk_s("simul_l1", l1, "TIME 23:53:57");

    // 13:05:00 in 12-hour display
    key(11); key(11);
    key(1); key(3); key(0); key(5); key(0); key(0);
    mode = 7'b0000011;
    read_frame(l1, l2);
    chk_s("h12_set_l1", l1, "TIME 01:05:00");
    chk_s("h12_set_l2", l2, "SET PM");
    mode = 7'b0000010;
    read_frame(l1, l2);
    chk_s("h12_run_l1", l1.substr(0, 11), "TIME 01:05:0");
    chk_s("h12_run_l2", l2, "RUN PM");

    chk("rw_low", rw_bad, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
